// File: rtl/multi_debouncer.sv
// N-channel push-button conditioner: 2-flop synchroniser, tick-sampled debounce,
// press/release pulses and a once-per-press long-press pulse.
module multi_debouncer #(
    parameter int N_CH         = 4,
    parameter int TICK_CYCLES  = 1000000,
    parameter int STABLE_TICKS = 2,
    parameter int LONG_TICKS   = 50,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] button,
    output logic [N_CH-1:0] held,
    output logic [N_CH-1:0] pressed,
    output logic [N_CH-1:0] released,
    output logic [N_CH-1:0] long_press,
    output logic            tick
);

    localparam int TW = $clog2(TICK_CYCLES);
    localparam int SW = $clog2(STABLE_TICKS + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);

    localparam logic [TW-1:0]   TIMER_RELOAD = TW'(TICK_CYCLES - 1);
    localparam logic [SW-1:0]   STAB_LAST    = SW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0]   HOLD_LAST    = HW'(LONG_TICKS - 1);
    localparam logic [HW-1:0]   HOLD_MAX     = HW'(LONG_TICKS);
    localparam logic [N_CH-1:0] IDLE_PIN     = {N_CH{ACTIVE_LOW}};

    logic [TW-1:0]   timer;
    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;
    logic [N_CH-1:0] s;
    logic [N_CH-1:0] held_d;
    logic [SW-1:0]   stab_cnt [N_CH];
    logic [HW-1:0]   hold_cnt [N_CH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= TIMER_RELOAD;
        end else if (timer == '0) begin
            timer <= TIMER_RELOAD;
        end else begin
            timer <= timer - TW'(1);
        end
    end

    assign tick = (timer == '0);

    // Sync flops idle at the inactive pin level so reset release looks like "not pressed".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IDLE_PIN;
            sync2 <= IDLE_PIN;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    assign s = ACTIVE_LOW ? ~sync2 : sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                stab_cnt[i] <= '0;
            end
        end else if (tick) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (s[i] == held[i]) begin
                    stab_cnt[i] <= '0;
                end else if (stab_cnt[i] == STAB_LAST) begin
                    held[i]     <= s[i];
                    stab_cnt[i] <= '0;
                end else begin
                    stab_cnt[i] <= stab_cnt[i] + SW'(1);
                end
            end
        end
    end

    // hold_cnt saturates at LONG_TICKS, so the LONG_TICKS-1 match can only occur once per press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            long_press <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                long_press[i] <= tick && held[i] && (hold_cnt[i] == HOLD_LAST);
                if (!held[i]) begin
                    hold_cnt[i] <= '0;
                end else if (tick && (hold_cnt[i] != HOLD_MAX)) begin
                    hold_cnt[i] <= hold_cnt[i] + HW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held_d <= '0;
        end else begin
            held_d <= held;
        end
    end

    assign pressed  = held & ~held_d;
    assign released = ~held & held_d;

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: cycle-level scoreboard plus directed latency and pulse-count checks,
// with an ACTIVE_LOW twin driven by inverted pins expected to match the same results.
module tb_multi_debouncer;

    localparam int N  = 4;
    localparam int TC = 4;
    localparam int ST = 3;
    localparam int LT = 5;

    typedef logic [4*N:0] obs_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] button;
    logic [N-1:0] button_n;

    logic [N-1:0] held_a, pressed_a, released_a, long_a;
    logic [N-1:0] held_b, pressed_b, released_b, long_b;
    logic         tick_a, tick_b;
    obs_t         obs_a, obs_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int cnt_press [N];
    int cnt_rel   [N];
    int cnt_long  [N];

    always #5 clk = ~clk;

    assign button_n = ~button;
    assign obs_a = {tick_a, held_a, pressed_a, released_a, long_a};
    assign obs_b = {tick_b, held_b, pressed_b, released_b, long_b};

    multi_debouncer #(
        .N_CH(N), .TICK_CYCLES(TC), .STABLE_TICKS(ST), .LONG_TICKS(LT), .ACTIVE_LOW(1'b0)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .button(button),
        .held(held_a), .pressed(pressed_a), .released(released_a),
        .long_press(long_a), .tick(tick_a)
    );

    multi_debouncer #(
        .N_CH(N), .TICK_CYCLES(TC), .STABLE_TICKS(ST), .LONG_TICKS(LT), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .button(button_n),
        .held(held_b), .pressed(pressed_b), .released(released_b),
        .long_press(long_b), .tick(tick_b)
    );

    // Reference model: pushes the expected post-edge outputs on every rising edge.
    obs_t         exp_q [$];
    int           m_timer;
    logic [N-1:0] m_s1, m_s2, m_held, m_held_d, m_long;
    int           m_stab [N];
    int           m_hold [N];

    task automatic model_reset();
        m_timer  = TC - 1;
        m_s1     = '0;
        m_s2     = '0;
        m_held   = '0;
        m_held_d = '0;
        m_long   = '0;
        for (int c = 0; c < N; c++) begin
            m_stab[c] = 0;
            m_hold[c] = 0;
        end
    endtask

    task automatic model_step();
        bit           tk;
        logic [N-1:0] smp;
        tk      = (m_timer == 0);
        smp     = m_s2;
        m_timer = tk ? TC - 1 : m_timer - 1;
        m_s2    = m_s1;
        m_s1    = button;
        for (int c = 0; c < N; c++) begin
            m_long[c] = tk && m_held[c] && (m_hold[c] == LT - 1);
            if (!m_held[c]) m_hold[c] = 0;
            else if (tk && m_hold[c] < LT) m_hold[c] = m_hold[c] + 1;
        end
        m_held_d = m_held;
        if (tk) begin
            for (int c = 0; c < N; c++) begin
                if (smp[c] == m_held[c]) begin
                    m_stab[c] = 0;
                end else if (m_stab[c] + 1 == ST) begin
                    m_held[c] = smp[c];
                    m_stab[c] = 0;
                end else begin
                    m_stab[c] = m_stab[c] + 1;
                end
            end
        end
    endtask

    always @(negedge reset_n) model_reset();

    always @(posedge clk) begin
        if (!reset_n) model_reset();
        else model_step();
        exp_q.push_back({(m_timer == 0), m_held, m_held & ~m_held_d, ~m_held & m_held_d, m_long});
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
        end
    endtask

    task automatic cycle();
        obs_t e;
        @(negedge clk);
        cyc++;
        check("scoreboard_nonempty", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("outputs_active_high", obs_a, e);
            check("outputs_active_low", obs_b, e);
        end
        for (int c = 0; c < N; c++) begin
            cnt_press[c] += pressed_a[c];
            cnt_rel[c]   += released_a[c];
            cnt_long[c]  += long_a[c];
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Leaves the bench at a sample where tick is high, so the next edge is a tick edge.
    task automatic align_tick();
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!tick_a && k < 2 * TC);
        check("align_tick", tick_a, 1);
    endtask

    task automatic wait_pulse(input string tag, input int kind, input int ch, input int budget,
                              input int exp_lat);
        int lat;
        bit found;
        lat   = 0;
        found = 0;
        while (!found && lat < budget) begin
            cycle();
            lat++;
            case (kind)
                0:       found = pressed_a[ch];
                1:       found = released_a[ch];
                default: found = long_a[ch];
            endcase
        end
        check({tag, "_seen"}, found, 1);
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    initial begin
        int first_tick;
        int n_ticks;
        int k;
        int rel3;

        for (int c = 0; c < N; c++) begin
            cnt_press[c] = 0;
            cnt_rel[c]   = 0;
            cnt_long[c]  = 0;
        end
        reset_n = 1'b0;
        button  = '0;

        // 1: reset state, then tick cadence with idle pins
        run(3);
        check("reset_state", obs_a, 0);
        reset_n    = 1'b1;
        first_tick = -1;
        n_ticks    = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (tick_a) begin
                if (first_tick < 0) first_tick = i;
                n_ticks++;
            end
        end
        check("first_tick_sample", first_tick, TC - 1);
        check("tick_count_40", n_ticks, 10);
        check("idle_no_press", cnt_press[0] + cnt_press[1] + cnt_press[2] + cnt_press[3], 0);

        // 2: single press: 2 sync edges, then the 3rd tick edge after s changes
        align_tick();
        button[0] = 1'b1;
        wait_pulse("press0", 0, 0, 40, 13);
        check("press0_only_ch0", pressed_a, 4'b0001);

        // 3: one disagreeing sample restarts the stability count
        align_tick();
        button[1] = 1'b1;
        run(9);
        button[1] = 1'b0;
        run(4);
        check("glitch_no_press1", cnt_press[1], 0);
        button[1] = 1'b1;
        wait_pulse("press1_after_glitch", 0, 1, 40, 12);

        // 4: long press fires once, release pulse after full debounce
        align_tick();
        button[2] = 1'b1;
        wait_pulse("press2", 0, 2, 40, 13);
        wait_pulse("long2", 2, 2, 40, 20);
        run(20 * TC);
        check("long2_once", cnt_long[2], 1);
        align_tick();
        button[2] = 1'b0;
        wait_pulse("release2", 1, 2, 40, 13);
        check("long2_no_refire", cnt_long[2], 1);

        // 5: simultaneous press on three channels
        button = '0;
        run(24);
        check("all_released", held_a, 0);
        button = 4'b1011;
        k = 0;
        do begin
            cycle();
            k++;
        end while (pressed_a == '0 && k < 40);
        check("multi_pressed_a", pressed_a, 4'b1011);
        check("multi_pressed_b", pressed_b, 4'b1011);

        // 6: reset mid-press, then the full debounce and long count again
        run(2 * TC);
        check("long3_not_yet", cnt_long[3], 0);
        rel3 = cnt_rel[3];
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_a", obs_a, 0);
        check("async_reset_b", obs_b, 0);
        run(2);
        reset_n = 1'b1;
        check("reset_no_release3", cnt_rel[3], rel3);
        wait_pulse("repress3", 0, 3, 40, 12);
        wait_pulse("long3", 2, 3, 40, 20);
        check("long3_once", cnt_long[3], 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
